// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-network blocks
// (synapse, neuron, saturating arithmetic).
package snn_pkg;

  localparam int I_W = 16;

  localparam logic signed [I_W-1:0] I_MAX = 16'sh7FFF;
  localparam logic signed [I_W-1:0] I_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFRACT = 2'd1,
    ACTIVE  = 2'd2
  } syn_state_e;

endpackage

// File: rtl/sat_add16.sv
// Signed 16-bit adder that clamps to [I_MIN, I_MAX] and flags the clamp.
module sat_add16
  import snn_pkg::*;
(
  input  logic signed [I_W-1:0] a,
  input  logic signed [I_W-1:0] b,
  output logic signed [I_W-1:0] sum,
  output logic                  ovf
);

  logic signed [I_W:0] wide;

  assign wide = {a[I_W-1], a} + {b[I_W-1], b};

  // The two top bits disagree exactly when the result left the 16-bit range.
  always_comb begin
    ovf = wide[I_W] ^ wide[I_W-1];
    sum = wide[I_W-1:0];
    if (ovf) sum = wide[I_W] ? I_MIN : I_MAX;
  end

endmodule

// File: rtl/synapse_current_gen.sv
// Spike-to-current synapse: each accepted spike edge adds a signed weight to
// a current that decays exponentially on a programmable prescaler tick.
//
// state   | meaning
// IDLE    | current is zero, edges accepted
// REFRACT | edge just accepted, further edges ignored while refr_cnt runs down
// ACTIVE  | current non-zero and decaying, edges accepted
module synapse_current_gen
  import snn_pkg::*;
#(
  parameter int REFRACT_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  spike_in,
  input  logic                  enable,
  input  logic signed [I_W-1:0] weight,
  input  logic [3:0]            decay_shift,
  input  logic [7:0]            decay_period,
  output logic signed [I_W-1:0] current_out,
  output logic [7:0]            spike_count,
  output logic                  saturated
);

  syn_state_e state_q, state_d;

  logic                  spike_d;
  logic [7:0]            presc;
  logic [7:0]            refr_cnt;
  logic                  spike_edge;
  logic                  tick;
  logic                  accept;
  logic                  decay_en;
  logic                  refr_busy;
  logic signed [I_W-1:0] shifted;
  logic signed [I_W-1:0] decay_step;
  logic signed [I_W-1:0] cur_dec;
  logic signed [I_W-1:0] sum_sat;
  logic                  add_ovf;

  assign spike_edge = spike_in & ~spike_d;
  assign tick       = enable & (presc == decay_period);
  assign accept     = enable & spike_edge & ~refr_busy;

  // Force a step of 1 for small positive currents so they actually reach zero.
  always_comb begin
    shifted    = current_out >>> decay_shift;
    decay_step = shifted;
    if (shifted == '0 && current_out > 0) decay_step = 16'sd1;
    cur_dec = (tick && decay_en) ? current_out - decay_step : current_out;
  end

  sat_add16 u_sat_add (
    .a   (cur_dec),
    .b   (weight),
    .sum (sum_sat),
    .ovf (add_ovf)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (enable) begin
      case (state_q)
        IDLE:    if (accept) state_d = REFRACT;
        REFRACT: if (refr_cnt == '0) state_d = (cur_dec != '0) ? ACTIVE : IDLE;
        ACTIVE: begin
          if (accept)              state_d = REFRACT;
          else if (cur_dec == '0)  state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    decay_en  = (state_q == ACTIVE) || (state_q == REFRACT);
    refr_busy = (state_q == REFRACT);
  end

  // spike_d resets high so a spike held through reset release is not an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spike_d     <= 1'b1;
      presc       <= '0;
      refr_cnt    <= '0;
      current_out <= '0;
      spike_count <= '0;
      saturated   <= 1'b0;
    end else begin
      spike_d <= spike_in;
      if (enable) begin
        presc <= tick ? 8'd0 : presc + 8'd1;
        if (accept) begin
          current_out <= sum_sat;
          spike_count <= spike_count + 8'd1;
          refr_cnt    <= 8'(REFRACT_CYCLES - 1);
          if (add_ovf) saturated <= 1'b1;
        end else begin
          current_out <= cur_dec;
          if (refr_busy && refr_cnt != '0) refr_cnt <= refr_cnt - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_synapse_current_gen.sv
// Self-checking bench for synapse_current_gen: directed scenarios plus a long
// randomized run against a behavioural model of the synapse.
module tb_synapse_current_gen;

  localparam int RC = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               spike_in;
  logic               enable;
  logic signed [15:0] weight;
  logic [3:0]         decay_shift;
  logic [7:0]         decay_period;
  logic signed [15:0] current_out;
  logic [7:0]         spike_count;
  logic               saturated;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model state
  int m_cur, m_cnt, m_presc, m_ecyc, m_last;
  bit m_sat, m_prev;

  synapse_current_gen #(.REFRACT_CYCLES(RC)) dut (
    .clock        (clock),
    .reset        (reset),
    .spike_in     (spike_in),
    .enable       (enable),
    .weight       (weight),
    .decay_shift  (decay_shift),
    .decay_period (decay_period),
    .current_out  (current_out),
    .spike_count  (spike_count),
    .saturated    (saturated)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_cur = 0; m_cnt = 0; m_sat = 0; m_presc = 0;
    m_ecyc = 0; m_last = -1000; m_prev = 1;
  endtask

  // Advance one clock: model consumes the inputs currently applied, then the
  // DUT is sampled on the following falling edge.
  task automatic step();
    int d, s;
    bit tk, acc;
    if (enable) begin
      tk = (m_presc == int'(decay_period));
      if (tk) begin
        d = m_cur >>> decay_shift;
        if (d == 0 && m_cur > 0) d = 1;
        m_cur = m_cur - d;
      end
      acc = spike_in && !m_prev && (m_ecyc - m_last >= RC + 1);
      if (acc) begin
        s = m_cur + int'(weight);
        if (s > 32767)  begin s = 32767;  m_sat = 1; end
        if (s < -32768) begin s = -32768; m_sat = 1; end
        m_cur  = s;
        m_cnt  = (m_cnt + 1) % 256;
        m_last = m_ecyc;
      end
      m_presc = tk ? 0 : (m_presc + 1) % 256;
      m_ecyc++;
    end
    m_prev = spike_in;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic apply_reset();
    spike_in = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (current_out !== 16'sd0) $display("FAIL reset_current: got %0d want 0", current_out);
    else n_pass++;
    n_checks++;
    if (spike_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", spike_count);
    else n_pass++;
    n_checks++;
    if (saturated !== 1'b0) $display("FAIL reset_sat: got %0b want 0", saturated);
    else n_pass++;
  endtask

  task automatic test_single_decay();
    int exp_seq[4] = '{1000, 750, 563, 423};
    int guard;
    apply_reset();
    weight = 16'sd1000; decay_shift = 4'd2; decay_period = 8'd0;
    step();
    spike_in = 1'b1;
    step();
    spike_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (current_out !== 16'(exp_seq[i]))
        $display("FAIL single_decay[%0d]: got %0d want %0d", i, current_out, exp_seq[i]);
      else n_pass++;
      step();
    end
    guard = 0;
    while (current_out != 0 && guard < 100) begin
      n_checks++;
      if (current_out !== 16'(m_cur))
        $display("FAIL single_decay_tail: got %0d want %0d", current_out, m_cur);
      else n_pass++;
      step();
      guard++;
    end
    n_checks++;
    if (current_out !== 16'sd0 || m_cur != 0)
      $display("FAIL single_decay_zero: got %0d model %0d want 0", current_out, m_cur);
    else n_pass++;
  endtask

  task automatic test_held_spike();
    apply_reset();
    weight = 16'sd50; decay_shift = 4'd15; decay_period = 8'd255;
    step();
    spike_in = 1'b1;
    for (int i = 0; i < 20; i++) step();
    n_checks++;
    if (spike_count !== 8'd1) $display("FAIL held_count: got %0d want 1", spike_count);
    else n_pass++;
    spike_in = 1'b0;
    for (int i = 0; i < 6; i++) step();
    spike_in = 1'b1; step();
    spike_in = 1'b0; step(); step();
    spike_in = 1'b1; step();
    n_checks++;
    if (spike_count !== 8'd2) $display("FAIL refract_edge3: got %0d want 2", spike_count);
    else n_pass++;
    spike_in = 1'b0; step();
    spike_in = 1'b1; step();
    n_checks++;
    if (spike_count !== 8'd3 || m_cnt != 3)
      $display("FAIL refract_edge5: got %0d model %0d want 3", spike_count, m_cnt);
    else n_pass++;
    spike_in = 1'b0; step();
  endtask

  task automatic test_saturation(input logic signed [15:0] w, input int want);
    apply_reset();
    weight = w; decay_shift = 4'd15; decay_period = 8'd255;
    step();
    spike_in = 1'b1; step();
    spike_in = 1'b0;
    for (int i = 0; i < 6; i++) step();
    spike_in = 1'b1; step();
    spike_in = 1'b0; step();
    n_checks++;
    if (current_out !== 16'(want) || m_cur != want)
      $display("FAIL sat_value: got %0d model %0d want %0d", current_out, m_cur, want);
    else n_pass++;
    n_checks++;
    if (saturated !== 1'b1) $display("FAIL sat_flag: got %0b want 1", saturated);
    else n_pass++;
  endtask

  task automatic test_tick_edge();
    int w, guard;
    apply_reset();
    weight = 16'sd800; decay_shift = 4'd1; decay_period = 8'd7;
    step();
    spike_in = 1'b1; step();
    spike_in = 1'b0;
    w = int'($urandom_range(0, 2000)) - 1000;
    weight = 16'(w);
    guard = 0;
    while (m_presc != 7 && guard < 20) begin
      step();
      guard++;
    end
    n_checks++;
    if (guard >= 20 || current_out !== 16'sd800)
      $display("FAIL tick_edge_setup: got %0d want 800 (guard %0d)", current_out, guard);
    else n_pass++;
    spike_in = 1'b1; step();
    spike_in = 1'b0;
    n_checks++;
    if (current_out !== 16'(400 + w))
      $display("FAIL tick_edge: got %0d want %0d", current_out, 400 + w);
    else n_pass++;
    step();
  endtask

  task automatic test_small_decay(input logic signed [15:0] w, input int len, input int seq[9]);
    apply_reset();
    weight = w; decay_shift = 4'd3; decay_period = 8'd0;
    step();
    spike_in = 1'b1; step();
    spike_in = 1'b0;
    for (int i = 0; i < len; i++) begin
      n_checks++;
      if (current_out !== 16'(seq[i]))
        $display("FAIL small_decay[%0d]: got %0d want %0d", i, current_out, seq[i]);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    weight = 16'sd5000; decay_shift = 4'd4; decay_period = 8'd1;
    step();
    spike_in = 1'b1;
    for (int i = 0; i < 4; i++) step();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (current_out !== 16'sd0 || spike_count !== 8'd0)
      $display("FAIL async_reset: current %0d count %0d want 0 0", current_out, spike_count);
    else n_pass++;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (spike_count !== 8'd0) $display("FAIL held_after_reset: got %0d want 0", spike_count);
    else n_pass++;
    spike_in = 1'b0; step();
    spike_in = 1'b1; step();
    n_checks++;
    if (spike_count !== 8'd1 || current_out !== 16'sd5000)
      $display("FAIL first_after_reset: count %0d cur %0d want 1 5000", spike_count, current_out);
    else n_pass++;
    spike_in = 1'b0; step();
  endtask

  task automatic test_random();
    apply_reset();
    enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 97 == 0) begin
        weight = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                 : 16'(int'($urandom_range(0, 4000)) - 2000);
        decay_shift = 4'($urandom_range(0, 15));
      end
      if (c % 131 == 0)
        decay_period = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                       : 8'($urandom_range(0, 6));
      spike_in = ($urandom_range(0, 2) == 0);
      enable   = ($urandom_range(0, 9) != 0);
      step();
      n_checks++;
      if (current_out !== 16'(m_cur) || spike_count !== 8'(m_cnt) || saturated !== m_sat) begin
        $display("FAIL random[%0d]: cur %0d cnt %0d sat %0b want %0d %0d %0b",
                 c, current_out, spike_count, saturated, m_cur, m_cnt, m_sat);
      end else n_pass++;
    end
    enable = 1'b1;
  endtask

  initial begin
    int neg_seq[9] = '{-8, -7, -6, -5, -4, -3, -2, -1, 0};
    int pos_seq[9] = '{3, 2, 1, 0, 0, 0, 0, 0, 0};
    reset = 1'b1; spike_in = 1'b0; enable = 1'b1;
    weight = '0; decay_shift = '0; decay_period = '0;
    model_reset();
    @(negedge clock);
    test_reset();
    test_single_decay();
    test_held_spike();
    test_saturation(16'sd20000, 32767);
    test_saturation(-16'sd20000, -32768);
    test_tick_edge();
    test_small_decay(-16'sd8, 9, neg_seq);
    test_small_decay(16'sd3, 5, pos_seq);
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/synapse_current_gen.md
# synapse_current_gen

Spike-to-current synapse: converts the 1-bit `spike` output of an upstream Hodgkin-Huxley neuron into the 16-bit `current_in` drive of a downstream neuron. Each accepted rising edge of `spike_in` adds a signed synaptic weight to an internal current, which then decays exponentially on a programmable tick. It is the receiving end of the neuron's spike interface and the transmitting end of the neuron's current interface, so neurons can be chained.

## Interface
- `REFRACT_CYCLES`, default 4: cycles after an accepted spike during which further edges are ignored (1..255).
- `clock`  in  1: single clock, all logic on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `spike_in`  in  1: level spike from the upstream neuron; may stay high for many cycles.
- `enable`  in  1: 0 freezes current, state, prescaler and counters; the edge register keeps sampling.
- `weight`  in  16: signed two's-complement increment per accepted spike.
- `decay_shift`  in  4: decay strength k; the decay step is I>>>k.
- `decay_period`  in  8: a decay tick fires every decay_period+1 enabled cycles.
- `current_out`  out  16: signed synaptic current, registered; connects to the neuron's `current_in`.
- `spike_count`  out  8: count of accepted spikes; wraps 255→0.
- `saturated`  out  1: sticky; set on any clamp, cleared only by reset.

## Operation
- Edge detect: `edge = spike_in & ~spike_d`. `spike_d` is registered every cycle regardless of `enable`.
- FSM states:
  - IDLE: current == 0, no refractory. On an enabled edge, go to REFRACT.
  - REFRACT: edges are ignored. `refr_cnt` counts down from REFRACT_CYCLES-1. At 0, go to ACTIVE if current ≠ 0, else IDLE.
  - ACTIVE: an edge goes to REFRACT. If the current reaches 0 with no edge, go to IDLE.
- Accepted edge: `current <= sat(current_after_decay + weight)`, `spike_count++`, `refr_cnt` loaded.
- Prescaler: free-runs 0..decay_period while enable=1. The tick fires in the cycle it equals decay_period, then the prescaler returns to 0.
- Decay on tick, in states ACTIVE and REFRACT:
  - `d = I>>>k` (arithmetic shift).
  - If d == 0 and I > 0, then d = 1, so positive currents reach 0.
  - Negative currents reach 0 naturally because -1>>>k = -1.
  - Result is I − d. With k = 0 the current goes straight to 0.
- Simultaneous tick and accepted edge: decay is applied first, then the weight is added, in one cycle.
- Arithmetic: the addition is 17-bit internally, then clamped to [-32768, 32767]. Any clamp sets `saturated`.
- `weight` = 0 is still an accepted spike: `spike_count` increments and the FSM enters REFRACT.

## Timing
- Reset (asynchronous, immediate):
  - `current_out` = 0, `spike_count` = 0, `saturated` = 0.
  - FSM = IDLE, prescaler = 0, `refr_cnt` = 0.
  - `spike_d` = 1, so a `spike_in` held high through reset release is not counted.
- Latency: `current_out` and `spike_count` update on the same clock edge that first samples `spike_in` = 1, i.e. one cycle after `spike_in` rises.
- Minimum accepted-spike spacing: REFRACT_CYCLES+1 cycles. An edge in the cycle REFRACT exits (refr_cnt = 0) is ignored. An edge in the next cycle is accepted.
- Reset mid-operation: all state is discarded at once. The first post-reset edge requires `spike_in` to go low and then high.
- enable=0 for N cycles: outputs hold. An edge that occurs while disabled is lost, because `spike_d` still updates.
- `decay_period` or `decay_shift` changed mid-run: takes effect on the next cycle. If the prescaler is already above the new period, it runs up to 255, wraps to 0, then continues normally.

## Structure
- Shared package `snn_pkg`:
  - `I_MAX` = 16'sh7FFF and `I_MIN` = 16'sh8000.
  - FSM state encoding (IDLE = 2'd0, REFRACT = 2'd1, ACTIVE = 2'd2).
  - Current width constant `I_W` = 16.
- One sub-module, `sat_add16`: combinational 16-bit signed add with clamp and overflow flag. It is reused by the neuron rework.
- Top level contains the edge register, prescaler, refractory counter, FSM and output registers.

## Test plan
- Reset, then a single spike: weight = 1000, k = 2, period = 0. `current_out` = 1000 one cycle after the edge, then 750, 563, 423… on successive cycles, reaching 0 and FSM = IDLE.
- Held spike: `spike_in` high for 20 cycles. Exactly one increment, `spike_count` = 1. A second edge at cycle 3 after the first (REFRACT_CYCLES = 4) is ignored. An edge at cycle 5 is accepted.
- Saturation: weight = 20000, k = 15, period = 255, two accepted spikes. `current_out` = 32767 and `saturated` = 1. Check the same with weight = -20000 giving -32768.
- Tick and edge in the same cycle: current = 800, k = 1, edge on a tick. Result is 800 − 400 + weight.
- Negative decay: weight = -8, k = 3, period = 0. Sequence -8, -7, -6, … reaching 0. Small positive: weight = 3, k = 3, sequence 3, 2, 1, 0.
- Asynchronous reset asserted mid-decay with `spike_in` held high. Outputs go to 0 immediately. No spike is counted after release until `spike_in` toggles low then high.
